// File: rtl/ram2_model_pkg.sv
// Shared constants for the RAM2 model: FSM state encodings, zero word and enable levels.
package ram2_model_pkg;

  typedef enum logic [1:0] {
    RAM2_IDLE   = 2'd0,
    RAM2_FETCH  = 2'd1,
    RAM2_MEM_RD = 2'd2,
    RAM2_MEM_WR = 2'd3
  } ram2_state_t;

  localparam logic [63:0] ZERO_WORD = 64'h0;

  localparam logic RAM_CHIP_ENABLE  = 1'b1;
  localparam logic RAM_READ_ENABLE  = 1'b1;
  localparam logic RAM_WRITE_ENABLE = 1'b1;

  localparam int CNT_W = 4;

  function automatic logic [CNT_W-1:0] lat_init(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/ram2_model_array.sv
// Storage array for the RAM2 model: synchronous write port, registered read port.
module ram2_model_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // NOTE: the array and its read register are deliberately not reset; a reset
  // loop over a memory would not map onto an SRAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/ram2_model.sv
// Shared instruction/data RAM2 model: data port has priority, fetch stalls while busy.
// Optional macro RAM2_TRACE_EN prints every completed access.
module ram2_model
  import ram2_model_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 12,
  parameter int LAT        = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid,
  output logic              stall_if,
  input  logic              mem_ce,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_ack
);

  localparam logic [CNT_W-1:0] LAT_INIT = lat_init(LAT);

  ram2_state_t           state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [DEPTH_LOG2-1:0] idx_q, req_idx, rd_idx;
  logic [DATA_W-1:0]     data_q, rd_data;
  logic                  data_req, done, wr_en;
  logic                  unused_addr;

  assign data_req = (mem_ce == RAM_CHIP_ENABLE) &&
                    ((mem_re == RAM_READ_ENABLE) || (mem_we == RAM_WRITE_ENABLE));
  assign req_idx  = data_req ? mem_addr_i[DEPTH_LOG2-1:0] : pc[DEPTH_LOG2-1:0];
  // Reading the incoming address while idle lets a LAT=1 access complete in time.
  assign rd_idx   = (state == RAM2_IDLE) ? req_idx : idx_q;
  assign wr_en    = done && (state == RAM2_MEM_WR) && !rst;
  assign unused_addr = ^{pc, mem_addr_i};

  assign stall_if = !rst && ((state == RAM2_MEM_RD) || (state == RAM2_MEM_WR) ||
                             ((state == RAM2_IDLE) && data_req));

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RAM2_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done       = 1'b0;
    case (state)
      RAM2_IDLE: begin
        cnt_next = LAT_INIT;
        if (data_req) state_next = (mem_we == RAM_WRITE_ENABLE) ? RAM2_MEM_WR : RAM2_MEM_RD;
        else          state_next = RAM2_FETCH;
      end
      default: begin
        if (cnt == '0) begin
          done       = 1'b1;
          state_next = RAM2_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == RAM2_IDLE) begin
      idx_q  <= req_idx;
      data_q <= mem_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_o     <= DATA_W'(ZERO_WORD);
      inst_valid <= 1'b0;
      mem_data_o <= DATA_W'(ZERO_WORD);
      mem_ack    <= 1'b0;
    end else begin
      inst_valid <= done && (state == RAM2_FETCH);
      mem_ack    <= done && (state != RAM2_FETCH);
      if (done && (state == RAM2_FETCH))  inst_o     <= rd_data;
      if (done && (state == RAM2_MEM_RD)) mem_data_o <= rd_data;
    end
  end

  ram2_model_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_idx (idx_q),
    .wr_data(data_q),
    .rd_idx (rd_idx),
    .rd_data(rd_data)
  );

`ifdef RAM2_TRACE_EN
  always @(posedge clk) begin
    if (!rst && done) begin
      case (state)
        RAM2_FETCH:  $display("%0t ram2 IF addr=%h data=%h", $time, idx_q, rd_data);
        RAM2_MEM_RD: $display("%0t ram2 RD addr=%h data=%h", $time, idx_q, rd_data);
        default:     $display("%0t ram2 WR addr=%h data=%h", $time, idx_q, data_q);
      endcase
    end
  end
`else
`endif

endmodule

// File: tb/tb_ram2_model.sv
// Self-checking bench for ram2_model: directed vector table, corner sequences, random traffic.
module tb_ram2_model;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int DEPTH_LOG2 = 12;
  localparam int LAT        = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] inst_o;
  logic              inst_valid, stall_if;
  logic              mem_ce, mem_re, mem_we;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_data_i, mem_data_o;
  logic              mem_ack;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ref_mem [int];
  logic [15:0] last_rd;
  logic [15:0] got;

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  ram2_model #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst_o(inst_o), .inst_valid(inst_valid),
    .stall_if(stall_if), .mem_ce(mem_ce), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .mem_ack(mem_ack)
  );

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [15:0] addr);
    return int'(addr) % DEPTH;
  endfunction

  // Must be entered in a cycle where the array is idle; returns in the ack cycle.
  task automatic do_access(input logic we, input logic re, input logic [15:0] addr,
                           input logic [15:0] wdata, output logic [15:0] rd);
    mem_ce = 1'b1; mem_we = we; mem_re = re; mem_addr_i = addr; mem_data_i = wdata;
    for (int i = 1; i <= LAT + 1; i++) begin
      tick();
      if (i == 1) begin
        mem_addr_i = 16'($urandom);
        mem_data_i = 16'($urandom);
      end
      check("acc_ack", 16'(mem_ack), 16'(i == LAT + 1));
      check("acc_stall", 16'(stall_if), 16'd1);
      check("acc_inst_valid", 16'(inst_valid), 16'd0);
    end
    rd = mem_data_o;
    if (we) ref_mem[idx_of(addr)] = wdata;
  endtask

  // Must be entered in a cycle where the array is idle; returns in the valid cycle.
  task automatic do_fetch(input logic [15:0] addr, output logic [15:0] inst);
    mem_ce = 1'b0; mem_we = 1'b0; mem_re = 1'b0; pc = addr;
    for (int i = 1; i <= LAT + 1; i++) begin
      tick();
      if (i == 1) pc = 16'($urandom);
      check("fetch_valid", 16'(inst_valid), 16'(i == LAT + 1));
      check("fetch_stall", 16'(stall_if), 16'd0);
      check("fetch_ack", 16'(mem_ack), 16'd0);
    end
    inst = inst_o;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 16'h0005, 16'h1234, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 16'h0005, 16'h0000, 16'h1234};
    tbl[2] = '{1'b1, 1'b0, 16'h0003, 16'hE151, 16'h1234};
    tbl[3] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h1234};
    tbl[4] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[5] = '{1'b1, 1'b0, 16'h1007, 16'hAAAA, 16'hBEEF};
    tbl[6] = '{1'b0, 1'b1, 16'h0007, 16'h0000, 16'hAAAA};
    tbl[7] = '{1'b0, 1'b1, 16'h0003, 16'h0000, 16'hE151};

    // Reset held two cycles with a data request pending.
    rst = 1'b1; pc = '0;
    mem_ce = 1'b1; mem_we = 1'b1; mem_re = 1'b1; mem_addr_i = 16'h0005; mem_data_i = 16'h1234;
    repeat (2) begin
      tick();
      check("rst_inst_o", inst_o, 16'h0000);
      check("rst_inst_valid", 16'(inst_valid), 16'd0);
      check("rst_mem_data_o", mem_data_o, 16'h0000);
      check("rst_mem_ack", 16'(mem_ack), 16'd0);
      check("rst_stall_if", 16'(stall_if), 16'd0);
    end
    rst = 1'b0;
    last_rd = 16'h0000;

    for (int k = 0; k < 8; k++) begin
      do_access(tbl[k].we, tbl[k].re, tbl[k].addr, tbl[k].wdata, got);
      check($sformatf("tbl%0d_data", k), got, tbl[k].exp_rd);
    end
    last_rd = 16'hE151;

    // Fetch in flight when a data read shows up: fetch finishes, then the read.
    mem_ce = 1'b0; mem_we = 1'b0; mem_re = 1'b0; pc = 16'h0003;
    tick();
    mem_ce = 1'b1; mem_re = 1'b1; mem_addr_i = 16'h0005;
    check("mid_fetch_stall", 16'(stall_if), 16'd0);
    for (int i = 2; i <= LAT; i++) begin
      tick();
      check("mid_fetch_valid", 16'(inst_valid), 16'd0);
      check("mid_fetch_stall", 16'(stall_if), 16'd0);
    end
    tick();
    check("mid_fetch_done", 16'(inst_valid), 16'd1);
    check("mid_fetch_inst", inst_o, 16'hE151);
    check("mid_fetch_req_stall", 16'(stall_if), 16'd1);
    check("mid_fetch_ack", 16'(mem_ack), 16'd0);
    do_access(1'b0, 1'b1, 16'h0005, 16'h0000, got);
    check("mid_fetch_rd", got, 16'h1234);
    last_rd = 16'h1234;

    do_fetch(16'h0010, got);
    check("fetch_beef", got, 16'hBEEF);

    // Random traffic against the reference array (addresses alias through the upper nibble).
    for (int k = 0; k < 16; k++) begin
      do_access(1'b1, 1'b0, 16'(k), 16'($urandom), got);
      check("fill_hold", got, last_rd);
    end
    for (int k = 0; k < 40; k++) begin
      logic [15:0] a, d, exp;
      int kind;
      a = {4'($urandom_range(0, 15)), 8'h00, 4'($urandom_range(0, 15))};
      d = 16'($urandom);
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        exp = ref_mem[idx_of(a)];
        do_fetch(a, got);
        check("rnd_fetch", got, exp);
      end else begin
        exp = (kind == 1) ? ref_mem[idx_of(a)] : last_rd;
        do_access(kind != 1, kind != 2, a, d, got);
        check("rnd_data", got, exp);
        last_rd = exp;
      end
    end

    // Reset one cycle after a write is accepted: no ack, old contents kept.
    mem_ce = 1'b1; mem_we = 1'b1; mem_re = 1'b0; mem_addr_i = 16'h0005; mem_data_i = 16'hDEAD;
    tick();
    check("rstw_stall", 16'(stall_if), 16'd1);
    rst = 1'b1; mem_ce = 1'b0; mem_we = 1'b0;
    tick();
    check("rstw_ack", 16'(mem_ack), 16'd0);
    check("rstw_mem_data_o", mem_data_o, 16'h0000);
    check("rstw_inst_o", inst_o, 16'h0000);
    rst = 1'b0;
    do_access(1'b0, 1'b1, 16'h0005, 16'h0000, got);
    check("rstw_preserved", got, ref_mem[5]);

    mem_ce = 1'b0; mem_we = 1'b0; mem_re = 1'b0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
